// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - register offsets, STAT field positions and priority helpers for int_ctrl
package int_ctrl_pkg;

  localparam int NUM_LINES = 8;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_STAT = 2'd3;

  localparam int STAT_ANY_BIT = 15;
  localparam int STAT_IDX_LSB = 0;
  localparam int STAT_IDX_W   = 3;

  // Index of the lowest set bit; 0 when nothing is set (STAT bit 15 disambiguates).
  function automatic logic [STAT_IDX_W-1:0] lowest_idx(input logic [NUM_LINES-1:0] v);
    logic [STAT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (v[i]) idx = STAT_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_LINES-1:0] lowest_onehot(input logic [NUM_LINES-1:0] v);
    return v & (~v + NUM_LINES'(1));
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// rtl/int_sync_edge.sv - per-line irq synchronizer with rising-edge detector
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // History always tracks the synchronized level, so a mode switch never sees a stale 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - 8-line interrupt controller; INT_CTRL_PRIORITY_EN selects one-hot lowest-line output
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  input  logic [15:0] address_bus,
  input  logic        r,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe,
  output logic [7:0]  interrupts
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("int_ctrl: SYNC_STAGES must be 2 or 3");
  end

  logic [NUM_LINES-1:0] level_s, rise_s;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk     (clk),
      .rst_n   (reset),
      .irq_i   (irq_in[i]),
      .level_o (level_s[i]),
      .rise_o  (rise_s[i])
    );
  end

  logic                  hit, wr_hit;
  logic [1:0]            offset;
  logic [NUM_LINES-1:0]  mask_q, mask_d, edge_q, edge_d, pend_edge_q, pend_edge_d;
  logic [NUM_LINES-1:0]  w1c, edge_chg, pend, active, irq_q, irq_d;
  logic                  stat_any_q, stat_any_d;
  logic [STAT_IDX_W-1:0] stat_idx_q, stat_idx_d;
  logic                  unused_data_hi;

  assign hit            = address_bus[15:2] == BASE_ADDR[15:2];
  assign offset         = address_bus[1:0];
  assign wr_hit         = wr && hit;
  assign unused_data_hi = ^data_in[15:NUM_LINES];

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    w1c    = '0;
    if (wr_hit) begin
      case (offset)
        OFF_PEND: w1c    = data_in[NUM_LINES-1:0];
        OFF_MASK: mask_d = data_in[NUM_LINES-1:0];
        OFF_EDGE: edge_d = data_in[NUM_LINES-1:0];
        default:  ;
      endcase
    end
  end

  // Set beats W1C; a mode change on a line discards whatever it had latched.
  assign edge_chg    = edge_d ^ edge_q;
  assign pend_edge_d = ~edge_chg & edge_q & ((pend_edge_q & ~w1c) | rise_s);

  assign pend   = (edge_q & pend_edge_q) | (~edge_q & level_s);
  assign active = pend & mask_q;

  always_comb begin
`ifdef INT_CTRL_PRIORITY_EN
    irq_d = lowest_onehot(active);
`else
    irq_d = active;
`endif
    stat_any_d = |active;
    stat_idx_d = lowest_idx(active);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q      <= '0;
      edge_q      <= '0;
      pend_edge_q <= '0;
      irq_q       <= '0;
      stat_any_q  <= 1'b0;
      stat_idx_q  <= '0;
    end else begin
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      pend_edge_q <= pend_edge_d;
      irq_q       <= irq_d;
      stat_any_q  <= stat_any_d;
      stat_idx_q  <= stat_idx_d;
    end
  end

  assign interrupts = irq_q;

  always_comb begin
    data_out = '0;
    data_oe  = 1'b0;
    if (r && hit && reset) begin
      data_oe = 1'b1;
      case (offset)
        OFF_PEND: data_out[NUM_LINES-1:0] = pend;
        OFF_MASK: data_out[NUM_LINES-1:0] = mask_q;
        OFF_EDGE: data_out[NUM_LINES-1:0] = edge_q;
        OFF_STAT: begin
          data_out[STAT_ANY_BIT]                    = stat_any_q;
          data_out[STAT_IDX_LSB +: STAT_IDX_W]      = stat_idx_q;
        end
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed bench for int_ctrl against a behavioural model
module tb_int_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int          S    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [15:0] address_bus = '0;
  logic        r = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_oe;
  logic [7:0]  interrupts;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_ctrl #(.BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .address_bus (address_bus),
    .r           (r),
    .wr          (wr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .interrupts  (interrupts)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: irq samples seen at each edge, newest first; index S is the synchronized value.
  logic [7:0] smp [1:S+1];
  logic [7:0] m_mask = '0, m_edge = '0, m_pe = '0, m_act = '0, m_int = '0;

  initial for (int k = 1; k <= S + 1; k++) smp[k] = '0;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [7:0] low_onehot(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_pend();
    return (m_edge & m_pe) | (~m_edge & smp[S]);
  endfunction

  function automatic logic [15:0] m_read();
    if (!(r && address_bus[15:2] == BASE[15:2] && reset)) return 16'h0000;
    case (address_bus[1:0])
      2'd0:    return {8'h00, m_pend()};
      2'd1:    return {8'h00, m_mask};
      2'd2:    return {8'h00, m_edge};
      default: return {(m_act != 0), 12'h000, low_idx(m_act)};
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] rise, act, w1c, nmask, nedge;
    if (!reset) begin
      m_mask = '0; m_edge = '0; m_pe = '0; m_act = '0; m_int = '0;
      for (int k = 1; k <= S + 1; k++) smp[k] = '0;
    end else begin
      rise  = smp[S] & ~smp[S+1];
      act   = m_pend() & m_mask;
      m_act = act;
`ifdef INT_CTRL_PRIORITY_EN
      m_int = low_onehot(act);
`else
      m_int = act;
`endif
      w1c = '0; nmask = m_mask; nedge = m_edge;
      if (wr && address_bus[15:2] == BASE[15:2]) begin
        case (address_bus[1:0])
          2'd0:    w1c   = data_in[7:0];
          2'd1:    nmask = data_in[7:0];
          2'd2:    nedge = data_in[7:0];
          default: ;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        if (nedge[i] != m_edge[i]) m_pe[i] = 1'b0;
        else if (!m_edge[i])       m_pe[i] = 1'b0;
        else if (rise[i])          m_pe[i] = 1'b1;
        else if (w1c[i])           m_pe[i] = 1'b0;
      end
      m_mask = nmask;
      m_edge = nedge;
      for (int k = S + 1; k >= 2; k--) smp[k] = smp[k-1];
      smp[1] = irq_in;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    check("interrupts", 32'(interrupts), 32'(m_int));
    check("data_out", 32'(data_out), 32'(m_read()));
    check("data_oe", 32'(data_oe), 32'(m_read() != 0 || (r && address_bus[15:2] == BASE[15:2] && reset)));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wreg(input logic [1:0] off, input logic [15:0] d);
    @(negedge clk);
    address_bus = BASE + {14'd0, off};
    data_in     = d;
    wr          = 1'b1;
    @(negedge clk);
    wr          = 1'b0;
    address_bus = 16'h0000;
  endtask

  task automatic rreg(input string name, input logic [15:0] addr, input logic [15:0] exp, input logic exp_oe);
    @(negedge clk);
    address_bus = addr;
    r = 1'b1;
    #1;
    check(name, 32'(data_out), 32'(exp));
    check({name, "_oe"}, 32'(data_oe), 32'(exp_oe));
    r = 1'b0;
    address_bus = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; irq_in = '0; wr = 1'b0; r = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    int lat;
    cyc(3);
    check("reset_int", 32'(interrupts), 32'h0);
    rreg("read_in_reset", BASE, 16'h0000, 1'b0);
    reset = 1'b1;
    cyc(2);
    rreg("rst_pend", BASE + 0, 16'h0000, 1'b1);
    rreg("rst_mask", BASE + 1, 16'h0000, 1'b1);
    rreg("rst_edge", BASE + 2, 16'h0000, 1'b1);
    rreg("rst_stat", BASE + 3, 16'h0000, 1'b1);

    // Single-cycle pulse on an edge line.
    wreg(2'd2, 16'h0001);
    wreg(2'd1, 16'h0001);
    @(negedge clk);
    irq_in = 8'h01;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) irq_in = 8'h00;
      if (lat == 0 && interrupts == 8'h01) lat = k;
    end
    check("edge_latency_le_4", 32'(lat >= 1 && lat <= S + 2), 32'h1);
    rreg("pend_held", BASE + 0, 16'h0001, 1'b1);
    wreg(2'd0, 16'h0001);
    @(posedge clk); #1;
    check("w1c_clears_int", 32'(interrupts), 32'h00);

    // Level lines, two active.
    do_reset();
    wreg(2'd1, 16'h00FF);
    @(negedge clk);
    irq_in = 8'h24;
    cyc(5);
    rreg("level_pend", BASE + 0, 16'h0024, 1'b1);
    rreg("level_stat", BASE + 3, 16'h8002, 1'b1);
`ifdef INT_CTRL_PRIORITY_EN
    check("level_int", 32'(interrupts), 32'h04);
`else
    check("level_int", 32'(interrupts), 32'h24);
`endif
    wreg(2'd3, 16'h0000);
    wreg(2'd0, 16'h00FF);
    rreg("level_pend_no_w1c", BASE + 0, 16'h0024, 1'b1);
    rreg("stat_wo_ignored", BASE + 3, 16'h8002, 1'b1);
    irq_in = 8'h00;
    cyc(4);

    // Masked edge becomes visible when unmasked.
    wreg(2'd1, 16'h0000);
    wreg(2'd2, 16'h0020);
    @(negedge clk);
    irq_in = 8'h20;
    cyc(6);
    irq_in = 8'h00;
    check("masked_int", 32'(interrupts), 32'h00);
    rreg("masked_pend", BASE + 0, 16'h0020, 1'b1);
    wreg(2'd1, 16'h0020);
    cyc(2);
    check("unmasked_int", 32'(interrupts), 32'h20);

    // W1C in the same cycle a new edge lands.
    do_reset();
    wreg(2'd2, 16'h0008);
    wreg(2'd1, 16'h0008);
    @(negedge clk);
    irq_in = 8'h08;
    cyc(1);
    irq_in = 8'h00;
    cyc(5);
    rreg("pend3_first", BASE + 0, 16'h0008, 1'b1);
    @(negedge clk);
    irq_in = 8'h08;
    cyc(1);
    wreg(2'd0, 16'h0008);
    rreg("set_beats_clear", BASE + 0, 16'h0008, 1'b1);
    irq_in = 8'h00;
    wreg(2'd0, 16'h0008);
    rreg("plain_w1c", BASE + 0, 16'h0000, 1'b1);

    // Reset mid-operation with all lines high, and a write colliding with reset.
    wreg(2'd2, 16'h00FF);
    wreg(2'd1, 16'h00FF);
    @(negedge clk);
    irq_in = 8'hFF;
    cyc(5);
    rreg("all_pend", BASE + 0, 16'h00FF, 1'b1);
    @(negedge clk);
    address_bus = BASE + 16'd1; data_in = 16'h00AA; wr = 1'b1; reset = 1'b0;
    cyc(1);
    wr = 1'b0;
    check("int_in_reset", 32'(interrupts), 32'h00);
    cyc(1);
    reset = 1'b1;
    rreg("mask_after_rst", BASE + 1, 16'h0000, 1'b1);
    rreg("edge_after_rst", BASE + 2, 16'h0000, 1'b1);
    cyc(4);
    wreg(2'd2, 16'h00FF);
    wreg(2'd1, 16'h00FF);
    cyc(4);
    rreg("no_spurious_edge", BASE + 0, 16'h0000, 1'b1);
    check("no_spurious_int", 32'(interrupts), 32'h00);
    irq_in = 8'h00;
    cyc(4);
    irq_in = 8'hFF;
    cyc(5);
    rreg("real_edge_after_rst", BASE + 0, 16'h00FF, 1'b1);

    // Address decode boundary.
    rreg("rd_base1", BASE + 16'd1, 16'h00FF, 1'b1);
    rreg("rd_base4", BASE + 16'd4, 16'h0000, 1'b0);

    // Randomized traffic checked every cycle by the compare process.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ 8'(1 << $urandom_range(0, 7));
      wr          = ($urandom_range(0, 4) == 0);
      r           = $urandom_range(0, 1) == 1;
      address_bus = ($urandom_range(0, 7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 3));
      data_in     = 16'($urandom);
      reset       = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    wr = 1'b0; r = 1'b0; reset = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00: base of the 4-word register window.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for irq_in, legal range 2..3.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port irq_in  input  8: asynchronous external interrupt lines.
REQ-006 SHALL have port address_bus  input  16: CPU address.
REQ-007 SHALL have port r  input  1: CPU read strobe.
REQ-008 SHALL have port wr  input  1: full-cycle CPU write enable (the ungated enable, not the clk-gated w).
REQ-009 SHALL have port data_in  input  16: CPU write data.
REQ-010 SHALL have port data_out  output  16: register read data.
REQ-011 SHALL have port data_oe  output  1: high when the top must drive data_out onto the CPU data bus.
REQ-012 SHALL have port interrupts  output  8: request vector feeding the CPU interrupts input.

Function
REQ-013 SHALL decode hit = address_bus[15:2] == BASE_ADDR[15:2]; offset = address_bus[1:0].
REQ-014 SHALL implement the register map: 0 PEND (R, W1C); 1 MASK (R/W, 1 = enabled); 2 EDGE (R/W, 1 = rising-edge, 0 = level-high); 3 STAT (R: bit 15 any-active, bits 2:0 index of lowest-numbered active line; WO-ignored).
REQ-015 SHALL use only bits 7:0 of PEND, MASK and EDGE; upper bits read 0 and writes to them are ignored.
REQ-016 SHALL drive data_out and data_oe combinationally from r && hit, with zero-cycle latency; otherwise data_out = 0 and data_oe = 0.
REQ-017 SHALL commit writes on the rising clk edge where wr && hit.
REQ-018 SHALL pass each irq_in bit through a SYNC_STAGES flop chain before any use.
REQ-019 SHALL, for an edge line, set PEND[i] on the cycle after a synchronized 0->1 transition is seen, and hold it until cleared.
REQ-020 SHALL, for a level line, have PEND[i] equal the synchronized input; W1C has no effect on it.
REQ-021 SHALL give set priority over clear when a W1C and a new edge occur on the same line in the same cycle.
REQ-022 SHALL latch edges regardless of MASK; masking gates only the outputs.
REQ-023 SHALL clear PEND[i] and the edge-detector history for line i in the same cycle on a write that changes EDGE[i], so no spurious edge is created.
REQ-024 SHALL define active = PEND & MASK; STAT and interrupts are registered from active, one cycle of latency.
REQ-025 SHALL meet a worst-case irq_in-to-interrupts latency of SYNC_STAGES + 2 clk cycles for an edge line.

Reset
REQ-026 SHALL, when reset is low, asynchronously clear synchronizers, edge history, PEND, MASK, EDGE (all level mode) and interrupts; data_out and data_oe are 0.
REQ-027 SHALL start with no spurious pending edge on the first cycle after reset release, even if irq_in is high.
REQ-028 SHALL abort any write coinciding with reset assertion; the reset values win.

Configuration
REQ-029 SHALL, with INT_CTRL_PRIORITY_EN defined, drive interrupts one-hot with only the lowest-numbered active line set (or all zero).
REQ-030 SHALL, without INT_CTRL_PRIORITY_EN, drive interrupts = active unmodified; STAT is identical in both builds.

Structure
REQ-031 SHALL place the register offsets (PEND, MASK, EDGE, STAT) and the STAT field positions in the shared cpu_data include as named constants.
REQ-032 SHALL factor the synchronizer plus edge detector into one sub-module, int_sync_edge (per-line, instantiated 8 times).

Verification
REQ-033 SHALL cover: EDGE=8'h01, MASK=8'h01, pulse irq_in[0] for 1 cycle -> interrupts=8'h01 within 4 cycles; PEND stays 8'h01 after the pulse; write PEND=8'h01 -> interrupts=8'h00 next cycle.
REQ-034 SHALL cover: level mode, MASK=8'hFF, irq_in=8'h24 held -> PEND reads 16'h0024, STAT reads 16'h8002; with priority build interrupts=8'h04, without it 8'h24.
REQ-035 SHALL cover: MASK=0, edge on line 5 -> interrupts=0; then MASK=8'h20 -> interrupts=8'h20 without a new edge.
REQ-036 SHALL cover: W1C of line 3 in the same cycle as a new edge on line 3 -> PEND[3] remains 1.
REQ-037 SHALL cover: reset low mid-operation, with PEND=8'hFF and irq_in=8'hFF held -> all registers 0; after release, EDGE=8'hFF yields no pending bits until irq_in drops and rises again.
REQ-038 SHALL cover: read at BASE_ADDR+1 with r=1 -> data_oe=1 in the same cycle; read at BASE_ADDR+4 -> data_oe=0.
